mbist_march_ctrl: RTL and testbench



---
 rtl/mbist_march_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer for the MBIST datapath.
// Walks the six March C- elements over the RAM under test, driving address,
// write/expected data and strobes, and collects a pass/fail verdict with the
// first failing address/element and a saturating mismatch count.
// Every output is a register so the RAM and comparator see glitch-free
// controls, and the asynchronous reset drops the strobes at once.
module mbist_march_ctrl #(
    parameter int          ADDR_W = 6,
    parameter logic [7:0]  BG     = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              eq,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data_t,
    output logic              ramwe,
    output logic              ramre,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CMP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [2:0]        ELEM_LAST = 3'd5;

    // Value each element expects when reading: "~d" in M2 and M4, "d" otherwise.
    function automatic logic [7:0] rd_val(input logic [2:0] e);
        case (e)
            3'd2, 3'd4: rd_val = ~BG;
            default:    rd_val = BG;
        endcase
    endfunction

    // Value each element writes: "~d" in M1 and M3, "d" otherwise.
    function automatic logic [7:0] wr_val(input logic [2:0] e);
        case (e)
            3'd1, 3'd3: wr_val = ~BG;
            default:    wr_val = BG;
        endcase
    endfunction

    // M3..M5 walk the array downwards.
    function automatic logic is_desc(input logic [2:0] e);
        is_desc = (e >= 3'd3);
    endfunction

    state_t            state_r, state_s;
    logic [2:0]        elem_r, elem_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [7:0]        data_r, data_s;
    logic              we_r, re_r, busy_r, done_r;
    logic              fail_r, fail_s;
    logic [ADDR_W-1:0] fail_addr_r, fail_addr_s;
    logic [2:0]        fail_elem_r, fail_elem_s;
    logic [7:0]        err_cnt_r, err_cnt_s;

    state_t            adv_state_s;
    logic [2:0]        adv_elem_s;
    logic [ADDR_W-1:0] adv_addr_s;
    logic [7:0]        adv_data_s;
    logic              terminal_s;

    // Where to go once the last op at the current address is finished.
    always_comb begin
        adv_state_s = ST_RD;
        adv_elem_s  = elem_r;
        adv_addr_s  = addr_r;
        adv_data_s  = rd_val(elem_r);
        terminal_s  = is_desc(elem_r) ? (addr_r == ADDR_ZERO) : (addr_r == ADDR_MAX);
        if (!terminal_s) begin
            adv_addr_s = is_desc(elem_r) ? (addr_r - ADDR_W'(1)) : (addr_r + ADDR_W'(1));
            if (elem_r == 3'd0) begin
                adv_state_s = ST_WR;
                adv_data_s  = wr_val(elem_r);
            end else begin
                adv_state_s = ST_RD;
                adv_data_s  = rd_val(elem_r);
            end
        end else if (elem_r == ELEM_LAST) begin
            adv_state_s = ST_DONE;
            adv_addr_s  = ADDR_ZERO;
            adv_data_s  = 8'h00;
        end else begin
            // Every element after M0 opens with a read.
            adv_elem_s  = elem_r + 3'd1;
            adv_addr_s  = is_desc(adv_elem_s) ? ADDR_MAX : ADDR_ZERO;
            adv_state_s = ST_RD;
            adv_data_s  = rd_val(adv_elem_s);
        end
    end

    // Next-state, next-address/data and result bookkeeping.
    always_comb begin
        state_s     = state_r;
        elem_s      = elem_r;
        addr_s      = addr_r;
        data_s      = data_r;
        fail_s      = fail_r;
        fail_addr_s = fail_addr_r;
        fail_elem_s = fail_elem_r;
        err_cnt_s   = err_cnt_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s     = ST_WR;
                    elem_s      = 3'd0;
                    addr_s      = ADDR_ZERO;
                    data_s      = wr_val(3'd0);
                    fail_s      = 1'b0;
                    fail_addr_s = ADDR_ZERO;
                    fail_elem_s = 3'd0;
                    err_cnt_s   = 8'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WR: begin
                state_s = adv_state_s;
                elem_s  = adv_elem_s;
                addr_s  = adv_addr_s;
                data_s  = adv_data_s;
            end
            ST_RD: begin
                // Address and expected data stay put while the RAM answers.
                state_s = ST_CMP;
            end
            ST_CMP: begin
                if (!eq) begin
                    err_cnt_s = (err_cnt_r == 8'hFF) ? err_cnt_r : (err_cnt_r + 8'd1);
                    if (!fail_r) begin
                        fail_s      = 1'b1;
                        fail_addr_s = addr_r;
                        fail_elem_s = elem_r;
                    end else begin
                        fail_s = fail_r;
                    end
                end else begin
                    err_cnt_s = err_cnt_r;
                end
                if (elem_r == ELEM_LAST) begin
                    state_s = adv_state_s;
                    elem_s  = adv_elem_s;
                    addr_s  = adv_addr_s;
                    data_s  = adv_data_s;
                end else begin
                    state_s = ST_WR;
                    data_s  = wr_val(elem_r);
                end
            end
            default: begin
                state_s = ST_IDLE;
                addr_s  = ADDR_ZERO;
                data_s  = 8'h00;
            end
        endcase
    end

    // State and output registers; reset aborts any run and clears all results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            elem_r      <= 3'd0;
            addr_r      <= ADDR_ZERO;
            data_r      <= 8'h00;
            we_r        <= 1'b0;
            re_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            fail_addr_r <= ADDR_ZERO;
            fail_elem_r <= 3'd0;
            err_cnt_r   <= 8'd0;
        end else begin
            state_r     <= state_s;
            elem_r      <= elem_s;
            addr_r      <= addr_s;
            data_r      <= data_s;
            we_r        <= (state_s == ST_WR);
            re_r        <= (state_s == ST_RD);
            busy_r      <= (state_s == ST_WR) || (state_s == ST_RD) || (state_s == ST_CMP);
            done_r      <= (state_s == ST_DONE);
            fail_r      <= fail_s;
            fail_addr_r <= fail_addr_s;
            fail_elem_r <= fail_elem_s;
            err_cnt_r   <= err_cnt_s;
        end
    end

    assign addr      = addr_r;
    assign data_t    = data_r;
    assign ramwe     = we_r;
    assign ramre     = re_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign fail      = fail_r;
    assign fail_addr = fail_addr_r;
    assign fail_elem = fail_elem_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two instances (16-word and 64-word RAMs) behind
// behavioural RAM models with optional stuck-at faults, checked cycle by cycle
// against an op list and verdict derived from the March C- element table.
module tb_mbist_march_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---- 16-word instance ----
    logic       start4 = 1'b0;
    logic       eq4;
    logic [3:0] addr4, faddr4;
    logic [7:0] data4, cnt4;
    logic       we4, re4, busy4, done4, fail4;
    logic [2:0] felem4;

    // ---- 64-word instance ----
    logic       start6 = 1'b0;
    logic       eq6;
    logic [5:0] addr6, faddr6;
    logic [7:0] data6, cnt6;
    logic       we6, re6, busy6, done6, fail6;
    logic [2:0] felem6;

    mbist_march_ctrl #(.ADDR_W(4), .BG(8'h00)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .eq(eq4),
        .addr(addr4), .data_t(data4), .ramwe(we4), .ramre(re4),
        .busy(busy4), .done(done4), .fail(fail4), .fail_addr(faddr4),
        .fail_elem(felem4), .err_cnt(cnt4));

    mbist_march_ctrl #(.ADDR_W(6), .BG(8'h5A)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .eq(eq6),
        .addr(addr6), .data_t(data6), .ramwe(we6), .ramre(re6),
        .busy(busy6), .done(done6), .fail(fail6), .fail_addr(faddr6),
        .fail_elem(felem6), .err_cnt(cnt6));

    // ---- fault injection and RAM models ----
    bit   f_en = 1'b0;
    int   f_addr = 0;
    int   f_bit = 0;
    bit   f_val = 1'b0;
    bit   force_neq = 1'b0;
    bit   noise = 1'b0;
    logic [7:0] mem4 [16];
    logic [7:0] mem6 [64];
    logic [7:0] rdata4, rdata6;

    function automatic logic [7:0] faulty(input logic [7:0] v, input int a);
        logic [7:0] r;
        r = v;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (we4) mem4[addr4] <= data4;
        if (re4) rdata4 <= faulty(mem4[addr4], int'(addr4));
        if (we6) mem6[addr6] <= data6;
        if (re6) rdata6 <= faulty(mem6[addr6], int'(addr6));
    end

    // eq outside a compare cycle is random junk the DUT must ignore.
    always @(negedge clk) noise <= 1'($urandom & 1);
    assign eq4 = (busy4 && !we4 && !re4) ? (rdata4 == data4) : noise;
    assign eq6 = (busy6 && !we6 && !re6) ? (!force_neq && rdata6 == data6) : noise;

    // ---- March C- as a table ----
    bit has_rd [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit rd_inv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit has_wr [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit wr_inv [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bit desc   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    typedef struct { bit we; bit re; int addr; logic [7:0] data; } op_t;
    typedef struct { bit fail; int addr; int elem; int cnt; int reads; } res_t;
    op_t exp_q[$];
    int  last_reads = 0;

    // Cycle-by-cycle op list: read costs RD + CMP (strobes low), write costs 1.
    function automatic void build(input int n, input logic [7:0] bg);
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < n; k++) begin
                int a;
                logic [7:0] rv, wv;
                a  = desc[e] ? (n - 1 - k) : k;
                rv = rd_inv[e] ? ~bg : bg;
                wv = wr_inv[e] ? ~bg : bg;
                if (has_rd[e]) begin
                    exp_q.push_back('{1'b0, 1'b1, a, rv});
                    exp_q.push_back('{1'b0, 1'b0, a, rv});
                end
                if (has_wr[e]) exp_q.push_back('{1'b1, 1'b0, a, wv});
            end
        end
    endfunction

    // Verdict of a March C- pass over a faulty RAM.
    function automatic res_t model(input int n, input logic [7:0] bg);
        logic [7:0] m [64];
        res_t r;
        r = '{1'b0, 0, 0, 0, 0};
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < n; k++) begin
                int a;
                logic [7:0] v, rv;
                a  = desc[e] ? (n - 1 - k) : k;
                rv = rd_inv[e] ? ~bg : bg;
                if (has_rd[e]) begin
                    v = faulty(m[a], a);
                    r.reads++;
                    if (force_neq || v != rv) begin
                        if (r.cnt < 255) r.cnt++;
                        if (!r.fail) begin
                            r.fail = 1'b1;
                            r.addr = a;
                            r.elem = e;
                        end
                    end
                end
                if (has_wr[e]) m[a] = wr_inv[e] ? ~bg : bg;
            end
        end
        return r;
    endfunction

    task automatic chk(input bit ok, input string name, input string act, input string req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %s, required %s", name, act, req);
        end
    endtask

    // Snapshot one instance's outputs as plain ints.
    task automatic sample(input int w, output bit s_we, output bit s_re, output int s_addr,
                          output logic [7:0] s_data, output bit s_busy, output bit s_done,
                          output bit s_fail, output int s_faddr, output int s_felem, output int s_cnt);
        if (w == 4) begin
            s_we = we4; s_re = re4; s_addr = int'(addr4); s_data = data4; s_busy = busy4;
            s_done = done4; s_fail = fail4; s_faddr = int'(faddr4); s_felem = int'(felem4);
            s_cnt = int'(cnt4);
        end else begin
            s_we = we6; s_re = re6; s_addr = int'(addr6); s_data = data6; s_busy = busy6;
            s_done = done6; s_fail = fail6; s_faddr = int'(faddr6); s_felem = int'(felem6);
            s_cnt = int'(cnt6);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        if (w == 4) start4 = v;
        else start6 = v;
    endtask

    task automatic check_zero(input string nm);
        chk({we4, re4, busy4, done4, fail4} == 5'd0 && addr4 == 4'd0 && data4 == 8'd0 &&
            faddr4 == 4'd0 && felem4 == 3'd0 && cnt4 == 8'd0, {nm, " dut4"},
            $sformatf("we=%0b re=%0b busy=%0b done=%0b fail=%0b addr=%0d data=%h cnt=%0d",
                      we4, re4, busy4, done4, fail4, addr4, data4, cnt4), "all zero");
        chk({we6, re6, busy6, done6, fail6} == 5'd0 && addr6 == 6'd0 && data6 == 8'd0 &&
            faddr6 == 6'd0 && felem6 == 3'd0 && cnt6 == 8'd0, {nm, " dut6"},
            $sformatf("we=%0b re=%0b busy=%0b done=%0b fail=%0b addr=%0d data=%h cnt=%0d",
                      we6, re6, busy6, done6, fail6, addr6, data6, cnt6), "all zero");
    endtask

    // One full run in lockstep with the op list, then the verdict.
    task automatic run(input int w, input bit hold, input string nm);
        int n, reads, bad_ops, first_bad;
        logic [7:0] bg;
        res_t r;
        bit s_we, s_re, s_busy, s_done, s_fail;
        int s_addr, s_faddr, s_felem, s_cnt;
        logic [7:0] s_data;
        string act_s;
        n = (w == 4) ? 16 : 64;
        bg = (w == 4) ? 8'h00 : 8'h5A;
        build(n, bg);
        r = model(n, bg);
        reads = 0; bad_ops = 0; first_bad = 0; act_s = "";
        @(negedge clk);
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_start(w, 1'b0);
        for (int c = 1; c <= 15 * n; c++) begin
            @(negedge clk);
            sample(w, s_we, s_re, s_addr, s_data, s_busy, s_done, s_fail, s_faddr, s_felem, s_cnt);
            if (c == 1)
                chk(!s_fail && s_cnt == 0 && !s_done, {nm, " cleared"},
                    $sformatf("fail=%0b cnt=%0d done=%0b", s_fail, s_cnt, s_done), "fail=0 cnt=0 done=0");
            if (!(s_we == exp_q[c-1].we && s_re == exp_q[c-1].re && s_addr == exp_q[c-1].addr &&
                  s_data == exp_q[c-1].data && s_busy && !s_done)) begin
                if (bad_ops == 0) begin
                    first_bad = c;
                    act_s = $sformatf("c%0d we=%0b re=%0b a=%0d d=%h busy=%0b vs we=%0b re=%0b a=%0d d=%h",
                                      c, s_we, s_re, s_addr, s_data, s_busy, exp_q[c-1].we,
                                      exp_q[c-1].re, exp_q[c-1].addr, exp_q[c-1].data);
                end
                bad_ops++;
            end
            if (s_re) reads++;
            if (hold && c == 15 * n) set_start(w, 1'b0);
        end
        chk(bad_ops == 0, {nm, " op sequence"}, $sformatf("%0d bad cycles, first %s", bad_ops, act_s),
            "every cycle matching March C-");
        @(negedge clk);
        sample(w, s_we, s_re, s_addr, s_data, s_busy, s_done, s_fail, s_faddr, s_felem, s_cnt);
        chk(s_done && !s_busy && !s_we && !s_re, {nm, " done timing"},
            $sformatf("done=%0b busy=%0b at cycle %0d", s_done, s_busy, 15 * n + 1), "done=1 busy=0");
        chk(s_fail == r.fail && s_cnt == r.cnt && (!r.fail || (s_faddr == r.addr && s_felem == r.elem)),
            {nm, " verdict"},
            $sformatf("fail=%0b addr=%0d elem=%0d cnt=%0d", s_fail, s_faddr, s_felem, s_cnt),
            $sformatf("fail=%0b addr=%0d elem=%0d cnt=%0d", r.fail, r.addr, r.elem, r.cnt));
        chk(reads == r.reads, {nm, " reads"}, $sformatf("%0d", reads), $sformatf("%0d", r.reads));
        last_reads = reads;
    endtask

    typedef struct {
        bit fen; int fa; int fb; bit fv;
        bit xfail; int xaddr; int xelem; int xcnt;
    } vec_t;
    vec_t tbl [5];

    initial begin
        // stuck-at faults on the 16-word RAM, BG = 00: SA1 fails d reads, SA0 fails ~d reads
        tbl[0] = '{1'b1, 5,  0, 1'b1, 1'b1, 5,  1, 3};
        tbl[1] = '{1'b0, 0,  0, 1'b0, 1'b0, 0,  0, 0};
        tbl[2] = '{1'b1, 0,  7, 1'b0, 1'b1, 0,  2, 2};
        tbl[3] = '{1'b1, 15, 3, 1'b1, 1'b1, 15, 1, 3};
        tbl[4] = '{1'b1, 9,  2, 1'b0, 1'b1, 9,  2, 2};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            f_en = tbl[i].fen; f_addr = tbl[i].fa; f_bit = tbl[i].fb; f_val = tbl[i].fv;
            run(4, 1'b0, $sformatf("vec%0d", i));
            chk(fail4 == tbl[i].xfail && cnt4 == 8'(tbl[i].xcnt) &&
                (!tbl[i].xfail || (int'(faddr4) == tbl[i].xaddr && int'(felem4) == tbl[i].xelem)),
                $sformatf("vec%0d table", i),
                $sformatf("fail=%0b addr=%0d elem=%0d cnt=%0d", fail4, faddr4, felem4, cnt4),
                $sformatf("fail=%0b addr=%0d elem=%0d cnt=%0d", tbl[i].xfail, tbl[i].xaddr,
                          tbl[i].xelem, tbl[i].xcnt));
        end

        // start held high across a whole run is ignored
        f_en = 1'b0;
        run(4, 1'b1, "hold_start");

        // comparator always reports mismatch on the 64-word instance
        force_neq = 1'b1;
        run(6, 1'b0, "always_neq");
        chk(cnt6 == 8'd255 && fail6 && faddr6 == 6'd0 && felem6 == 3'd1 && last_reads == 320,
            "always_neq hand", $sformatf("cnt=%0d addr=%0d elem=%0d reads=%0d", cnt6, faddr6, felem6, last_reads),
            "cnt=255 addr=0 elem=1 reads=320");
        force_neq = 1'b0;

        // random single stuck-at faults
        for (int i = 0; i < 6; i++) begin
            f_en = 1'($urandom_range(3, 0) != 0);
            f_addr = $urandom_range(15, 0); f_bit = $urandom_range(7, 0); f_val = 1'($urandom & 1);
            run(4, 1'b0, $sformatf("rnd4_%0d", i));
        end
        for (int i = 0; i < 2; i++) begin
            f_en = 1'b1;
            f_addr = $urandom_range(63, 0); f_bit = $urandom_range(7, 0); f_val = 1'($urandom & 1);
            run(6, 1'b0, $sformatf("rnd6_%0d", i));
        end
        f_en = 1'b0;

        // reset asserted in cycle 100 (an M2 write) of a run
        build(16, 8'h00);
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (100) @(negedge clk);
        chk(we4 == 1'b1 && busy4, "pre-reset strobe", $sformatf("we=%0b busy=%0b", we4, busy4), "we=1 busy=1");
        rst_n = 1'b0;
        #1;
        check_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        run(4, 1'b0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
